// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: registered ROM address, one fetch in flight,
// two-entry {pc, word} queue toward decode, with redirect flush.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [31:0] q_pc   [2];
  logic [31:0] q_word [2];
  logic        head;
  logic [1:0]  count;

  logic        pop;
  logic        issue;
  logic        write;
  logic        tail;
  logic [1:0]  occ;

  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid && inst_ready;
  assign write      = inflight && !redirect;
  assign tail       = head ^ count[0];

  // Slots still owed to the queue after this cycle's pop.
  assign occ   = count - {1'b0, pop} + {1'b0, inflight};
  assign issue = fetch_en && !redirect && (occ < 2'd2);

  assign rom_addr = fetch_pc;
  assign inst_out = inst_valid ? q_word[head] : 32'h0;
  assign pc_out   = inst_valid ? q_pc[head]   : 32'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC & ~32'h3;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= 2'd0;
      head        <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      count    <= 2'd0;
      head     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      count <= count - {1'b0, pop} + {1'b0, write};
      if (pop)
        head <= ~head;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && write) begin
      q_pc[tail]   <= inflight_pc;
      q_word[tail] <= rom_data;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic,
// checked against a timestamped queue of issued fetch addresses.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  int checks = 0;
  int fails  = 0;

  fetch_sequencer #(.RESET_PC(32'h00000000)) dut (
    .clock       (clock),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .pc_out      (pc_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ 32'h5A5A0000;
  endfunction

  // ROM outputs zero while held in reset
  always @(posedge clock)
    rom_data <= reset ? 32'h0 : rom_word(rom_addr);

  typedef struct {
    logic [31:0] pc;
    int          avail;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  int          now = 0;
  bit          model_ok = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h",
             tag, now, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic fe, input logic rdy,
                      input logic rd, input logic [31:0] rpc);
    logic        e_valid;
    logic [31:0] e_pc;
    logic        pop;
    @(negedge clock);
    e_valid = (q.size() > 0) && (q[0].avail <= now);
    e_pc    = e_valid ? q[0].pc : 32'h0;
    if (model_ok) begin
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
      chk("pc_out", pc_out, e_pc);
      chk("inst_out", inst_out, e_valid ? rom_word(e_pc) : 32'h0);
      chk("rom_addr", rom_addr, m_pc);
    end
    reset       = r;
    fetch_en    = fe;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    pop = e_valid && rdy;
    if (r) begin
      q.delete();
      m_pc     = 32'h0;
      model_ok = 1;
    end else begin
      if (pop)
        void'(q.pop_front());
      if (rd) begin
        q.delete();
        m_pc = rpc & ~32'h3;
      end else if (fe && q.size() < 2) begin
        q.push_back('{pc: m_pc, avail: now + 2});
        m_pc = m_pc + 32'd4;
      end
    end
    now++;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h100);
    // free run from reset pc
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
    // downstream stall, then release
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    // redirect with queue loaded
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 32'h43);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    // redirect concurrent with pop, to the wrap point
    step(0, 1, 1, 1, 32'hFFFFFFFC);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    // reset pulse together with redirect while full
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 32'h200);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    // fetch disabled: drain, then hold
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom % 4 == 0) ? (32'hFFFFFFF0 | ($urandom % 16))
                                : $urandom;
      step(($urandom % 150) == 0, ($urandom % 8) != 0,
           ($urandom % 3) != 0, ($urandom % 25) == 0, rpc);
    end
    step(0, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the fetch address loaded at reset.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rom_addr  output  32  byte address driven to the instruction ROM.
REQ-005 SHALL have port rom_data  input  32  ROM word for the address presented on the previous cycle; 1-cycle registered latency.
REQ-006 SHALL have port fetch_en  input  1  high permits new fetches to be issued.
REQ-007 SHALL have port redirect  input  1  branch/jump redirect request; flushes all queued and in-flight fetches.
REQ-008 SHALL have port redirect_pc  input  32  target address for redirect.
REQ-009 SHALL have port inst_valid  output  1  inst_out/pc_out hold a valid instruction.
REQ-010 SHALL have port inst_ready  input  1  downstream accepts the instruction; transfer occurs when inst_valid && inst_ready.
REQ-011 SHALL have port inst_out  output  32  instruction word at the head of the queue.
REQ-012 SHALL have port pc_out  output  32  byte address of inst_out.

Function
REQ-013 State: fetch_pc (32b), inflight flag plus its PC, 2-entry FIFO of {pc, word}, 2-bit count.
REQ-014 rom_addr SHALL equal fetch_pc[31:2],2'b00, driven from a register, with no combinational path from any input.
REQ-015 pop = inst_valid && inst_ready; inst_valid = (count != 0); the FIFO head drives inst_out and pc_out.
REQ-016 inst_out and pc_out SHALL be 32'h0 whenever inst_valid is 0.
REQ-017 issue = fetch_en && !redirect && (count - pop + inflight) < 2; on issue: inflight <= 1 with PC fetch_pc, and fetch_pc <= fetch_pc + 4.
REQ-018 On a cycle without issue, fetch_pc SHALL hold and inflight <= 0; the ROM re-reads the same address harmlessly.
REQ-019 When inflight is 1, rom_data SHALL be written to the FIFO tail with the inflight PC at the end of that cycle, unless redirect is asserted.
REQ-020 Latency: rom_addr presented in cycle t gives inst_valid in cycle t+2; a sustained throughput of 1 instruction/cycle SHALL be achieved while inst_ready=1 and fetch_en=1.
REQ-021 The FIFO SHALL never overflow; instructions SHALL be delivered in order with no loss or duplication under any inst_ready pattern.
REQ-022 Redirect sampled at end of cycle t: the FIFO empties, inflight clears, and fetch_pc <= {redirect_pc[31:2],2'b00}; rom_addr = target in t+1; the first target instruction is valid in t+3.
REQ-023 Redirect concurrent with pop: the handshake in cycle t SHALL complete, then the flush applies; inst_valid=0 from t+1 to t+2.
REQ-024 Redirect SHALL take priority over issue and FIFO write; a write of in-flight data in the same cycle is discarded.
REQ-025 fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-026 fetch_en low: no issue; an in-flight word still lands; queued words drain normally.

Reset
REQ-027 Reset SHALL take priority over every other input, including redirect.
REQ-028 On reset: fetch_pc <= RESET_PC (low 2 bits cleared), count <= 0, inflight <= 0.
REQ-029 The cycle after reset: inst_valid=0, inst_out=0, pc_out=0, rom_addr=RESET_PC.
REQ-030 Reset asserted mid-operation SHALL discard all queued and in-flight instructions; the ROM reset-zero output SHALL never be enqueued.
REQ-031 First cycle with reset low = t0: issue at RESET_PC in t0, and the first inst_valid in t0+2.

Verification
REQ-032 ROM word[i]=i, RESET_PC=0, fetch_en=1, inst_ready=1 -> inst_valid at t0+2, pc_out 0,4,8,... each cycle, inst_out 0,1,2,... with no bubbles.
REQ-033 Free-run, then inst_ready=0 for 5 cycles -> count saturates at 2, rom_addr holds, and on release the sequence resumes with no gap, duplicate or loss.
REQ-034 Redirect to 0x43 with FIFO full and inflight=1 in cycle t -> inst_valid=0 in t+1 and t+2; pc_out=0x40, inst_out=word[16] in t+3.
REQ-035 Redirect to 0xFFFFFFFC -> pc_out 0xFFFFFFFC then 0x00000000 on consecutive accepts.
REQ-036 Reset pulsed for 1 cycle while FIFO full, together with redirect=1 -> next cycle inst_valid=0, rom_addr=RESET_PC; delivery restarts at RESET_PC two cycles after reset release.
REQ-037 fetch_en=0 with inst_ready=1 -> the in-flight word plus queued words (at most 2) drain, then inst_valid stays 0 and rom_addr stays constant until fetch_en=1.
